// File: rtl/divu_hilo_pkg.sv
// Shared funct codes, FSM state encoding and divider constants.
// Optional macro: DIVU_ZERO_FAST_EN (short-circuit divide-by-zero).
package divu_hilo_pkg;

    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_DIVU = 6'b011011;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = $clog2(DIV_STEPS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } divu_state_e;

endpackage

// File: rtl/divu_hilo_step.sv
// One restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and record the quotient bit.
module divu_step
    import divu_hilo_pkg::*;
(
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] div_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;
    logic        unused_rem_msb;

    // The partial remainder stays below the divisor, so its MSB
    // is always shifted out.
    assign unused_rem_msb = rem_i[32];

    assign shifted = {rem_i[31:0], quo_i[31]};
    assign diff    = shifted - {1'b0, div_i};
    assign fits    = shifted >= {1'b0, div_i};

    assign rem_o = fits ? diff : shifted;
    assign quo_o = {quo_i[30:0], fits};

endmodule

// File: rtl/divu_hilo.sv
// Multi-cycle unsigned divider writing HI (remainder) / LO (quotient).
// Optional macro: DIVU_ZERO_FAST_EN finishes divide-by-zero early.
module divu_hilo
    import divu_hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        busy,
    output logic        done
);

    divu_state_e state_q, state_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [32:0] rem_n;
    logic [31:0] quo_n;
    logic        zero_fast;
    logic        last_step;
    logic        unused_rem_n_msb;

    divu_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (rem_n),
        .quo_o (quo_n)
    );

    assign unused_rem_n_msb = rem_n[32];

`ifdef DIVU_ZERO_FAST_EN
    assign zero_fast = (div_q == 32'd0);
`else
    assign zero_fast = 1'b0;
`endif

    assign last_step = (cnt_q == CNT_W'(DIV_STEPS - 1));

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Signal == FN_DIVU) begin
                    quo_d   = dataA;
                    div_d   = dataB;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (zero_fast) begin
                    // Dividend is still untouched in the quotient register.
                    hi_d    = quo_q;
                    lo_d    = 32'hFFFF_FFFF;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_step) begin
                        hi_d    = rem_n[31:0];
                        lo_d    = quo_n;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign HiOut = hi_q;
    assign LoOut = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_divu_hilo.sv
// Directed bench for divu_hilo: latency, results, busy/done,
// ignored re-issue, async reset mid-run and back-to-back issue.
module tb_divu_hilo;
    import divu_hilo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        busy;
    logic        done;

    int tests;
    int fails;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

`ifdef DIVU_ZERO_FAST_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 33;
`endif

    divu_hilo dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .HiOut  (HiOut),
        .LoOut  (LoOut),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one DIVU and follow it to its done pulse.
    task automatic run_div(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input int lat,
                           input bit inject);
        int n;
        int busy_bad;
        int hold_bad;
        @(negedge clk);
        dataA  = a;
        dataB  = b;
        Signal = FN_DIVU;
        tick();
        Signal = FN_ADD;
        n = 1;
        busy_bad = 0;
        hold_bad = 0;
        while (done !== 1'b1 && n < 80) begin
            if (busy !== 1'b1) busy_bad++;
            if (HiOut !== prev_hi || LoOut !== prev_lo) hold_bad++;
            if (inject && n == 4) begin
                dataA  = 32'd9;
                dataB  = 32'd3;
                Signal = FN_DIVU;
            end
            if (inject && n == 10) Signal = FN_SUB;
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_busy_run"}, 32'(busy_bad), 32'd0);
        chk({tag, "_hold_old"}, 32'(hold_bad), 32'd0);
        chk({tag, "_lo"}, LoOut, exp_lo);
        chk({tag, "_hi"}, HiOut, exp_hi);
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    initial begin
        int pulses;
        int n;
        tests   = 0;
        fails   = 0;
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        rst_n   = 1'b0;
        dataA   = 32'd0;
        dataB   = 32'd0;
        Signal  = 6'd0;
        #12;
        chk("rst_hi", HiOut, 32'd0);
        chk("rst_lo", LoOut, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
        run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
        run_div("d5_9", 32'd5, 32'd9, 32'd0, 32'd5, 33, 1'b0);
        run_div("d1234_0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234,
                ZERO_LAT, 1'b0);
        run_div("inject", 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1);

        // No restart from the ignored mid-run DIVU; other functs are inert.
        @(negedge clk);
        dataA  = 32'd77;
        dataB  = 32'd5;
        pulses = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            unique case (i % 4)
                0: Signal = FN_MFHI;
                1: Signal = FN_MFLO;
                2: Signal = FN_SLT;
                default: Signal = FN_OR;
            endcase
            tick();
            if (done === 1'b1) pulses++;
            if (busy !== 1'b0) n++;
        end
        chk("quiet_done", 32'(pulses), 32'd0);
        chk("quiet_busy", 32'(n), 32'd0);
        chk("quiet_hi", HiOut, 32'd2);
        chk("quiet_lo", LoOut, 32'd14);

        // Asynchronous reset during run cycle 10.
        @(negedge clk);
        dataA  = 32'd100;
        dataB  = 32'd7;
        Signal = FN_DIVU;
        tick();
        Signal = FN_AND;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_hi", HiOut, 32'd0);
        chk("arst_lo", LoOut, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) pulses++;
            if (busy !== 1'b0) n++;
        end
        chk("arst_no_done", 32'(pulses), 32'd0);
        chk("arst_stay_idle", 32'(n), 32'd0);

        // Back-to-back: DIVU held high across DONE->IDLE.
        @(negedge clk);
        dataA  = 32'd100;
        dataB  = 32'd7;
        Signal = FN_DIVU;
        tick();
        dataA = 32'd9;
        dataB = 32'd3;
        n = 1;
        while (done !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        chk("b2b_lat1", 32'(n), 32'd33);
        chk("b2b_lo1", LoOut, 32'd14);
        chk("b2b_hi1", HiOut, 32'd2);
        tick();
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("b2b_accept2", 32'(busy), 32'd1);
        Signal = FN_SRL;
        n = 1;
        while (done !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        chk("b2b_lat2", 32'(n), 32'd33);
        chk("b2b_lo2", LoOut, 32'd3);
        chk("b2b_hi2", HiOut, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/divu_hilo.md
DIVU_HILO -- requirements
Module: divu_hilo

Interface
REQ-001 The block SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-003 dataA  in  32  SHALL carry the unsigned dividend (rs).
REQ-004 dataB  in  32  SHALL carry the unsigned divisor (rt).
REQ-005 Signal  in  6  SHALL carry the funct code; DIVU = 6'b011011.
REQ-006 HiOut  out  32  SHALL carry the registered HI value (remainder), feeding the result mux.
REQ-007 LoOut  out  32  SHALL carry the registered LO value (quotient), feeding the result mux.
REQ-008 busy  out  1  SHALL be high while a divide is in progress.
REQ-009 done  out  1  SHALL be a one-cycle pulse when HI/LO update.

Function
REQ-010 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-011 In IDLE with Signal==DIVU at a clk edge, the block SHALL latch dataA and dataB, clear the remainder accumulator, load counter=0 and enter RUN.
REQ-012 RUN SHALL perform one restoring step per cycle: rem = {rem[31:0], quo[31]}; quo <<= 1; if rem >= divisor then rem -= divisor and quo[0]=1.
REQ-013 The remainder accumulator SHALL be 33 bits wide; the quotient and divisor SHALL be 32 bits wide.
REQ-014 RUN SHALL last exactly 32 cycles, then transition to DONE.
REQ-015 On entry to DONE, HiOut SHALL take the remainder and LoOut SHALL take the quotient in the same edge; done SHALL be high for that one cycle, and the block SHALL return to IDLE on the next edge.
REQ-016 Latency SHALL be 33 edges from the accepting edge to the HiOut/LoOut update.
REQ-017 busy SHALL be high in RUN and DONE, and low in IDLE.
REQ-018 HiOut/LoOut SHALL hold their previous values throughout RUN; MFHI/MFLO issued during RUN read the old values.
REQ-019 Signal==DIVU while busy SHALL be ignored, with no restart and no queuing.
REQ-020 Signal==DIVU in the same cycle the block returns to IDLE SHALL be accepted on the following edge per REQ-011.
REQ-021 With divisor 0, the default behaviour SHALL run the full 32 cycles and yield LoOut=32'hFFFFFFFF and HiOut=dividend.
REQ-022 All non-DIVU funct codes SHALL have no effect on the block.

Reset
REQ-023 An rst_n low SHALL asynchronously force IDLE, HiOut=0, LoOut=0, busy=0, done=0, counter=0 and clear internal registers, including mid-RUN.
REQ-024 After rst_n deasserts, the first accepting edge SHALL be governed only by REQ-011.

Configuration
REQ-025 With DIVU_ZERO_FAST_EN defined, a DIVU accepted with dataB==0 SHALL skip RUN and enter DONE on the accepting edge's next edge (latency 2 edges), with results as in REQ-021.
REQ-026 Without DIVU_ZERO_FAST_EN, divide-by-zero SHALL follow REQ-021 with the full 33-edge latency.

Structure
REQ-027 A shared package SHALL hold the funct constants (AND, OR, ADD, SUB, SLT, SRL, DIVU, MFHI, MFLO), which are shared with the result mux, plus the FSM state enum.
REQ-028 A package constant DIV_STEPS = 32 SHALL set the counter terminal value.
REQ-029 One combinational sub-module, divu_step, SHALL implement a single restoring step (inputs rem, quo, divisor; outputs next rem and next quo).

Verification
REQ-030 The bench SHALL cover: reset, then DIVU with A=100, B=7 -> busy for 33 edges; done pulse; LoOut=14, HiOut=2.
REQ-031 The bench SHALL cover: A=32'hFFFFFFFF, B=1 -> LoOut=32'hFFFFFFFF, HiOut=0; then A=5, B=9 -> LoOut=0, HiOut=5.
REQ-032 The bench SHALL cover: A=1234, B=0 -> LoOut=32'hFFFFFFFF, HiOut=1234; done at edge 33 without the macro and at edge 2 with it.
REQ-033 The bench SHALL cover: a second DIVU (A=9, B=3) asserted mid-RUN of 100/7 -> ignored; results 14/2; no second done pulse.
REQ-034 The bench SHALL cover: rst_n pulsed low at RUN cycle 10 of 100/7 -> immediate IDLE, HiOut=LoOut=0, busy=0, no done pulse.
REQ-035 The bench SHALL cover: back-to-back DIVU held high -> new divide accepted on the edge after DONE→IDLE; results of both divides correct.
